// File: rtl/lsu_pkg.sv
// Shared types for the load/store sequencer: FSM state encoding, size codes
// and the size-to-byte-count helper.
package lsu_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT   = 3'd2;
    localparam logic [2:0] ST_WR_SETUP  = 3'd3;
    localparam logic [2:0] ST_WR_STROBE = 3'd4;
    localparam logic [2:0] ST_ERR       = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_RD_ISSUE  = ST_RD_ISSUE,
        S_RD_WAIT   = ST_RD_WAIT,
        S_WR_SETUP  = ST_WR_SETUP,
        S_WR_STROBE = ST_WR_STROBE,
        S_ERR       = ST_ERR,
        S_DONE      = ST_DONE
    } lsu_state_e;

    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_W = 3'd1;
    localparam logic [2:0] SZ_L = 3'd2;
    localparam logic [2:0] SZ_Q = 3'd3;

    function automatic logic [7:0] bytes_of(input logic [2:0] size);
        return 8'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_seq_if.sv
// Core request/response and byte-memory port bundle for lsu_seq.
// slave is the sequencer side; master is the core + memory side.
interface lsu_seq_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [7:0]        mem_rdata;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic              mem_write;
    logic              mem_ready;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_rdata, mem_ready,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output mem_raddr, mem_waddr, mem_wdata, mem_write
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_rdata, mem_ready,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  mem_raddr, mem_waddr, mem_wdata, mem_write
    );
endinterface

// File: rtl/lsu_extend.sv
// Widens an N-byte right-aligned load accumulator to DATA_W, filling the
// upper bytes with zero or the loaded sign bit.
module lsu_extend
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [2:0]        size,
    input  logic              signed_en,
    output logic [DATA_W-1:0] ext
);
    localparam int NB = DATA_W / 8;

    logic [7:0] nb;
    logic       sign_bit;
    logic       fill;

    assign nb = bytes_of(size);

    // Sign lives in the top bit of the most significant loaded byte.
    always_comb begin
        sign_bit = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (b == int'(nb) - 1) sign_bit = acc[b*8+7];
        end
    end

    assign fill = signed_en & sign_bit;

    for (genvar b = 0; b < NB; b++) begin : g_byte
        assign ext[b*8 +: 8] = (b < int'(nb)) ? acc[b*8 +: 8] : {8{fill}};
    end

endmodule

// File: rtl/lsu_seq.sv
// Single-outstanding load/store sequencer: splits a 1..DATA_W/8 byte request
// into big-endian byte accesses on a read/write-port byte memory.
module lsu_seq
    import lsu_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic      clk,
    input  logic      reset,
    lsu_seq_if.slave  bus
);
    localparam int NB     = DATA_W / 8;
    localparam int CNT_W  = $clog2(NB) + 1;
    localparam int WAIT_W = $clog2(READ_LAT + 1);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] mem_raddr_q, mem_raddr_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              mem_write_q, mem_write_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              last_byte;
    logic [DATA_W-1:0] ext_data;
    int                wr_shift;

    lsu_extend #(.DATA_W(DATA_W)) u_extend (
        .acc       (acc_d),
        .size      (size_d),
        .signed_en (signed_d),
        .ext       (ext_data)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        signed_d    = signed_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        mem_raddr_d = mem_raddr_q;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        wr_shift    = 0;
        last_byte   = (cnt_q == CNT_W'(bytes_of(size_q) - 8'd1));

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = bus.req_addr;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    write_d  = bus.req_write;
                    wdata_d  = bus.req_wdata;
                    cnt_d    = '0;
                    acc_d    = '0;
                    if (int'(bytes_of(bus.req_size)) * 8 > DATA_W) state_d = S_ERR;
                    else if (bus.req_write)                        state_d = S_WR_SETUP;
                    else                                           state_d = S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: begin
                wcnt_d  = WAIT_W'(1);
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // Only the final wait cycle may capture; a stalled memory holds us here.
                if (wcnt_q == WAIT_W'(READ_LAT)) begin
                    if (bus.mem_ready) begin
                        acc_d = (acc_q << 8) | DATA_W'(bus.mem_rdata);
                        if (last_byte) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = S_RD_ISSUE;
                        end
                    end
                end else begin
                    wcnt_d = wcnt_q + WAIT_W'(1);
                end
            end
            S_WR_SETUP: begin
                if (bus.mem_ready) state_d = S_WR_STROBE;
            end
            S_WR_STROBE: begin
                if (last_byte) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_WR_SETUP;
                end
            end
            S_ERR:   state_d = S_IDLE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Registered outputs are derived from the next state so they line up with it.
        if (state_d == S_RD_ISSUE) mem_raddr_d = addr_d + ADDR_W'(cnt_d);
        if (state_d == S_WR_SETUP) begin
            wr_shift    = (int'(bytes_of(size_d)) - 1 - int'(cnt_d)) * 8;
            mem_waddr_d = addr_d + ADDR_W'(cnt_d);
            mem_wdata_d = 8'(wdata_d >> wr_shift);
        end
        mem_write_d = (state_d == S_WR_STROBE);
        rsp_valid_d = (state_d == S_DONE) || (state_d == S_ERR);
        rsp_err_d   = (state_d == S_ERR);
        if (state_d == S_DONE && !write_d) rsp_rdata_d = ext_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            signed_q    <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            mem_raddr_q <= '0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            mem_write_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            mem_raddr_q <= mem_raddr_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_write_q <= mem_write_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_raddr = mem_raddr_q;
    assign bus.mem_waddr = mem_waddr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_write = mem_write_q;

endmodule

// File: tb/tb_lsu_seq.sv
// Scoreboard bench for lsu_seq: byte memory model, response queue with
// latency/data expectations, and logs of read addresses and write strobes.
module tb_lsu_seq;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int RL = 1;

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
        int            lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lsu_seq_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    lsu_seq #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int n_rsp = 0;
    int stall_s = 0;
    int stall_len = 0;
    logic chk_ready_next = 1'b0;

    exp_t          sb[$];
    logic [AW-1:0] ra_log[$];
    logic [AW+7:0] wr_log[$];
    logic [AW-1:0] prev_raddr = '0;
    logic [7:0]    mem [0:(1<<AW)-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Read port with a one-cycle registered latency (READ_LAT=1).
    always @(posedge clk) bus.mem_rdata <= mem[bus.mem_raddr];

    always @(posedge clk) begin
        #1;
        bus.mem_ready = !(stall_len > 0 && cyc >= stall_s && cyc < stall_s + stall_len);
    end

    always @(negedge clk) begin
        exp_t e;
        if (chk_ready_next) begin
            check("ready_after_rsp", 64'(bus.req_ready), 64'd1);
            chk_ready_next = 1'b0;
        end
        if (bus.rsp_valid === 1'b1) begin
            n_rsp++;
            chk_ready_next = 1'b1;
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                check("rsp_lat", 64'(cyc - accept_cyc), 64'(e.lat));
            end
        end
        if (bus.mem_write === 1'b1) begin
            wr_log.push_back({bus.mem_waddr, bus.mem_wdata});
            mem[bus.mem_waddr] = bus.mem_wdata;
        end
        if (bus.mem_raddr != prev_raddr) ra_log.push_back(bus.mem_raddr);
        prev_raddr = bus.mem_raddr;
    end

    task automatic do_req(input logic w, input logic [2:0] sz, input logic sg,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic e_err, input logic [DW-1:0] e_rd, input int lat,
                          input int soff, input int slen);
        exp_t e;
        int   n0;
        e.err = e_err; e.rdata = e_rd; e.lat = lat;
        sb.push_back(e);
        n0 = n_rsp;
        ra_log.delete();
        wr_log.delete();
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        accept_cyc     = cyc;
        stall_s        = cyc + soff;
        stall_len      = slen;
        @(posedge clk); #1;
        // Scramble inputs after acceptance; the sequencer must have latched them.
        bus.req_valid  = 1'b0;
        bus.req_write  = ~w;
        bus.req_size   = 3'd0;
        bus.req_signed = ~sg;
        bus.req_addr   = ~a;
        bus.req_wdata  = ~wd;
        for (int i = 0; i < 100 && n_rsp == n0; i++) @(negedge clk);
        @(negedge clk);
        check("rsp_seen", 64'(n_rsp != n0), 64'd1);
        if (n_rsp == n0 && sb.size() > 0) void'(sb.pop_front());
        stall_len = 0;
    endtask

    initial begin
        int n_before;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        mem[9'h010] = 8'h80; mem[9'h011] = 8'h12; mem[9'h012] = 8'h34; mem[9'h013] = 8'h56;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 3'd0;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        check("rst_mem_write", 64'(bus.mem_write), 64'd0);
        check("rst_mem_addrs", 64'({bus.mem_raddr, bus.mem_waddr, bus.mem_wdata}), 64'd0);

        // Word load, unstalled
        do_req(1'b0, 3'd2, 1'b0, 9'h010, '0, 1'b0, 32'h80123456, 9, 0, 0);
        check("t1_raddr_n", 64'(ra_log.size()), 64'd4);
        for (int k = 0; k < ra_log.size() && k < 4; k++)
            check("t1_raddr", 64'(ra_log[k]), 64'(9'h010 + k));

        // Byte and halfword loads, signed and unsigned
        do_req(1'b0, 3'd0, 1'b1, 9'h010, '0, 1'b0, 32'hFFFFFF80, 3, 0, 0);
        do_req(1'b0, 3'd1, 1'b0, 9'h011, '0, 1'b0, 32'h00001234, 5, 0, 0);
        do_req(1'b0, 3'd1, 1'b1, 9'h010, '0, 1'b0, 32'hFFFF8012, 5, 0, 0);

        // Word store across the address wrap; rsp_rdata holds the last load
        do_req(1'b1, 3'd2, 1'b0, 9'h1FE, 32'hDEADBEEF, 1'b0, 32'hFFFF8012, 9, 0, 0);
        check("t3_wr_n", 64'(wr_log.size()), 64'd4);
        if (wr_log.size() == 4) begin
            check("t3_wr0", 64'(wr_log[0]), 64'({9'h1FE, 8'hDE}));
            check("t3_wr1", 64'(wr_log[1]), 64'({9'h1FF, 8'hAD}));
            check("t3_wr2", 64'(wr_log[2]), 64'({9'h000, 8'hBE}));
            check("t3_wr3", 64'(wr_log[3]), 64'({9'h001, 8'hEF}));
        end
        check("t3_raddr_quiet", 64'(ra_log.size()), 64'd0);

        // Read back the wrapped word
        do_req(1'b0, 3'd2, 1'b1, 9'h1FE, '0, 1'b0, 32'hDEADBEEF, 9, 0, 0);
        check("rb_raddr_wrap", 64'(ra_log.size() > 2 ? ra_log[2] : 9'h1FF), 64'(9'h000));

        // Word load with a 3-cycle memory stall on byte 1 capture
        do_req(1'b0, 3'd2, 1'b0, 9'h010, '0, 1'b0, 32'h80123456, 12, 4, 3);
        check("t4_raddr_n", 64'(ra_log.size()), 64'd4);
        check("t4_raddr1", 64'(ra_log.size() > 1 ? ra_log[1] : 9'h000), 64'(9'h011));

        // Unsupported size: error response, no memory traffic
        do_req(1'b0, 3'd3, 1'b0, 9'h020, '0, 1'b1, 32'h80123456, 1, 0, 0);
        check("t5_ld_raddr_quiet", 64'(ra_log.size()), 64'd0);
        do_req(1'b1, 3'd3, 1'b0, 9'h020, 32'h01020304, 1'b1, 32'h80123456, 1, 0, 0);
        check("t5_st_no_write", 64'(wr_log.size()), 64'd0);

        // Reset in the middle of a store, right after its second strobe
        n_before = n_rsp;
        wr_log.delete();
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 3'd2;
        bus.req_addr = 9'h040; bus.req_wdata = 32'h11223344;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 50 && wr_log.size() < 2; i++) begin
            @(negedge clk); #1;
        end
        check("t6_two_strobes", 64'(wr_log.size()), 64'd2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_req_ready", 64'(bus.req_ready), 64'd1);
        check("t6_outs_zero", 64'({bus.mem_raddr, bus.mem_waddr, bus.mem_wdata, bus.mem_write}), 64'd0);
        check("t6_rsp_zero", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 64'd0);
        repeat (12) @(negedge clk);
        check("t6_no_more_writes", 64'(wr_log.size()), 64'd2);
        check("t6_no_rsp", 64'(n_rsp - n_before), 64'd0);
        check("t6_mem_partial", 64'({mem[9'h040], mem[9'h041], mem[9'h042]}), 64'({8'h11, 8'h22, 8'h00}));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
